// File: rtl/riviera_pkg.sv
// Shared types and widths for the Riviera front end.
package riviera_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry register FIFO of fetched {pc, instr}; slot 0 is always the head.
module fetch_fifo
  import riviera_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  logic [1:0]   count_reg;
  fetch_entry_t slot_reg [2];
  logic         pop_ok;

  assign pop_ok = pop && (count_reg != 2'd0);
  assign head   = slot_reg[0];
  assign count  = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          slot_reg[count_reg[0]] <= push_data;
          count_reg              <= count_reg + 2'd1;
        end
        2'b01: begin
          slot_reg[0] <= slot_reg[1];
          count_reg   <= count_reg - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_reg == 2'd2) begin
            slot_reg[0] <= slot_reg[1];
            slot_reg[1] <= push_data;
          end else begin
            slot_reg[0] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push && !pop_ok) assert (count_reg != 2'd2);
  end
`endif

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: drives a 1-cycle synchronous code memory and streams
// {pc, instr} to decode with credit-based flow control and redirects.
module ifetch_stage #(
  parameter int              XLEN       = 64,
  parameter int              ADDR_WIDTH = 11,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [63:0]           i_mem_rdata,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_pc,
  output logic                  o_valid,
  output logic [31:0]           o_instr,
  output logic [XLEN-1:0]       o_pc,
  input  logic                  i_ready
);

  import riviera_pkg::*;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] inflight_pc_reg;
  logic            inflight_reg;

  logic [1:0]      count;
  logic            pop;
  logic            issue;
  logic [2:0]      occupancy;
  fetch_entry_t    push_data;
  fetch_entry_t    head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  assign pop       = (count != 2'd0) && i_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight_reg};
  // pop implies count >= 1, so the subtraction never underflows.
  assign issue     = !i_redirect && ((occupancy - {2'b00, pop}) < 3'd2);

  assign push_data.pc    = inflight_pc_reg;
  assign push_data.instr = inflight_pc_reg[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
    end else if (i_redirect) begin
      fetch_pc_reg <= {i_redirect_pc[XLEN-1:2], 2'b00};
      inflight_reg <= 1'b0;
    end else if (issue) begin
      fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
      inflight_pc_reg <= fetch_pc_reg;
      inflight_reg    <= 1'b1;
    end else begin
      inflight_reg <= 1'b0;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .flush     (i_redirect),
    .head      (head),
    .count     (count)
  );

  assign o_mem_addr = fetch_pc_reg[ADDR_WIDTH+2:3];
  assign o_valid    = (count != 2'd0);
  assign o_instr    = head.instr;
  assign o_pc       = head.pc;

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

- Instruction fetch stage of the Riviera core, sitting directly upstream of the synchronous single-port code memory.
- Drives the code memory word address every cycle and consumes its 64-bit read data one cycle later.
- Selects the addressed 32-bit instruction half and presents `{pc, instr}` to decode through a valid/ready handshake.
- Supports full-throughput streaming, decode back-pressure, and redirects from branch/jump resolution.

## Interface

Parameters:
- `XLEN`, 64, PC width.
- `ADDR_WIDTH`, 11, code memory word-address width (64-bit words).
- `RESET_PC`, 0, fetch address after reset. Must be 4-byte aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `o_mem_addr` out `ADDR_WIDTH`: code memory word address, equal to `fetch_pc[ADDR_WIDTH+2:3]`. Driven from a register only.
- `i_mem_rdata` in 64: code memory read data, valid one cycle after the address.
- `i_redirect` in 1: flush and restart fetch.
- `i_redirect_pc` in `XLEN`: new fetch PC. Bits [1:0] are ignored and treated as 0.
- `o_valid` out 1: instruction available to decode.
- `o_instr` out 32: instruction word.
- `o_pc` out `XLEN`: byte PC of `o_instr`.
- `i_ready` in 1: decode accepts when `o_valid && i_ready`.

## Operation

- State:
  - `fetch_pc`
  - `inflight` and `inflight_pc`
  - 2-entry output FIFO of `{pc, instr}`, with `count` in 0..2.
- Issue:
  - An issue occurs when `!i_redirect && (count + inflight - pop) < 2`, where `pop = o_valid && i_ready`.
  - On issue: `inflight <= 1`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`.
  - Otherwise `inflight <= 0` and `fetch_pc` holds.
- Return:
  - When `inflight` is 1, push `{inflight_pc, inflight_pc[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0]}`.
  - Every instruction costs one memory read, even when it shares a 64-bit word with the previous one.
- FIFO:
  - Push and pop in the same cycle are legal at any count.
  - Pushing when full is impossible by the credit rule above. Assert it in simulation.
- Redirect:
  - In the redirect cycle, the FIFO is flushed (`count <= 0`), `inflight <= 0` (returning data discarded), and `fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00}`.
  - A pop handshaked in the same cycle still counts as consumed by decode.
  - Redirect has priority over issue, push, and pop bookkeeping.
- Arithmetic:
  - PC increment wraps modulo 2^XLEN.
  - PC bits above `ADDR_WIDTH+2` do not reach the memory, so fetch wraps modulo the memory size.
- `o_valid = (count != 0)`. `o_instr` and `o_pc` come from the FIFO head and are held stable while `o_valid && !i_ready`.

## Timing

- Reset values:
  - `fetch_pc = RESET_PC`, so `o_mem_addr = RESET_PC[ADDR_WIDTH+2:3]`.
  - `inflight = 0`, `count = 0`.
  - `o_valid = 0`, `o_instr = 0`, `o_pc = 0`.
- Latency: an issue in cycle N reads memory data in N+1, pushes at the end of N+1, and raises `o_valid` in N+2. First `o_valid` appears in the 3rd cycle after reset deassertion.
- Throughput: with `i_ready` held high, one instruction per cycle in steady state.
- Back-pressure: with `i_ready` low, at most 2 instructions are buffered and no further issue occurs. Raising `i_ready` resumes at full rate with no bubble.
- Redirect: a redirect asserted in cycle R gives `o_valid = 0` in R+1 and R+2. The target is issued in R+1 and appears in R+3.
- Combinational paths:
  - `i_ready` feeds only the issue enable.
  - No path exists from `i_ready` or `i_redirect` to `o_mem_addr`, `o_valid`, or `o_instr`.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Fetch restarts at `RESET_PC` after deassertion.

## Structure

- `riviera_pkg` holds:
  - `XLEN`
  - `INSTR_WIDTH = 32`
  - `fetch_entry_t` struct `{logic [XLEN-1:0] pc; logic [31:0] instr;}`
- Sub-module `fetch_fifo`:
  - 2-entry register FIFO of `fetch_entry_t`, with push, pop, flush, and count.
  - Asynchronous active-low reset. Head is visible combinationally.

## Test plan

- Reset with `RESET_PC=0`, `i_ready=1`, memory word0=`0x00200093_00100013`, word1=`0x00400193_00300113`:
  - `o_valid` rises 3rd cycle after reset.
  - Outputs on consecutive cycles: (0,`0x00100013`), (4,`0x00200093`), (8,`0x00300113`), (C,`0x00400193`).
- Hold `i_ready=0` for 10 cycles mid-stream:
  - No more than 2 entries are buffered.
  - `o_pc` and `o_instr` are stable throughout.
  - After release, PCs continue with no gap or duplicate, one per cycle.
- `i_redirect=1`, `i_redirect_pc=0x106` while FIFO is full and inflight:
  - `o_valid` is low for 2 cycles.
  - Next output has `o_pc=0x104`, taken from the upper half of word `0x20`.
  - No old-path instruction appears.
- Back-to-back redirects to `0x40` then `0x80` on consecutive cycles: only the `0x80` stream appears, first at the 3rd cycle after the second redirect.
- PC wrap: redirect to `(2^(ADDR_WIDTH+3))-4`, so `o_mem_addr` is all ones. Next fetch uses `o_mem_addr=0` and `o_pc` continues as the unwrapped +4.
- `rst_n` pulsed low mid-stream for one cycle: `o_valid` is 0 immediately, and the stream restarts from `RESET_PC`.
